// File: rtl/alu_pkg.sv
// Shared types and constants for the accumulator ALU.
// Opcode enums, data width and the combinational result bundle.
package alu_pkg;

  localparam int WIDTH = 8;

  typedef enum logic [3:0] {
    R_ADD  = 4'd0,
    R_LOAD = 4'd1,
    R_MVFR = 4'd2,
    R_MVTO = 4'd3,
    R_OR   = 4'd4,
    R_XOR  = 4'd5,
    R_XORR = 4'd6,
    R_AND  = 4'd7,
    R_STR  = 4'd8,
    R_SLT  = 4'd9,
    R_SEQ  = 4'd10,
    R_BTRU = 4'd11,
    R_SUB  = 4'd12
  } r_op_t;

  typedef enum logic [2:0] {
    I_LI   = 3'd0,
    I_ADDI = 3'd1,
    I_SUBI = 3'd2,
    I_B    = 3'd3,
    I_LSLI = 3'd4,
    I_LSRI = 3'd5
  } i_op_t;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             br;
    logic             cy;
  } alu_res_t;

endpackage

// File: rtl/alu_comb.sv
// Combinational opcode decode and datapath of the accumulator ALU.
// Produces next result, branch-taken and carry/borrow.
module alu_comb
  import alu_pkg::*;
(
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [4:0]       imm,
  input  logic             typ,
  input  logic [3:0]       r_op,
  input  logic [2:0]       i_op,
  output alu_res_t         nxt
);

  logic [WIDTH-1:0] imm_x;
  logic [WIDTH:0]   add_ab;
  logic [WIDTH:0]   sub_ab;
  logic [WIDTH:0]   add_ai;
  logic [WIDTH:0]   sub_ai;
  logic             big_sh;

  assign imm_x  = {3'b000, imm};
  assign add_ab = {1'b0, a} + {1'b0, b};
  assign sub_ab = {1'b0, a} - {1'b0, b};
  assign add_ai = {1'b0, a} + {1'b0, imm_x};
  assign sub_ai = {1'b0, a} - {1'b0, imm_x};
  assign big_sh = |imm[4:3];

  // Only the opcode field selected by typ is decoded
  always_comb begin
    nxt = '0;
    if (typ) begin
      unique case (i_op)
        I_LI:   nxt.res = imm_x;
        I_ADDI: begin
          nxt.res = add_ai[WIDTH-1:0];
          nxt.cy  = add_ai[WIDTH];
        end
        I_SUBI: begin
          nxt.res = sub_ai[WIDTH-1:0];
          nxt.cy  = sub_ai[WIDTH];
        end
        I_B: begin
          nxt.res = a;
          nxt.br  = 1'b1;
        end
        I_LSLI: nxt.res = big_sh ? '0 : a << imm[2:0];
        I_LSRI: nxt.res = big_sh ? '0 : a >> imm[2:0];
        default: nxt.res = '0;
      endcase
    end else begin
      unique case (r_op)
        R_ADD: begin
          nxt.res = add_ab[WIDTH-1:0];
          nxt.cy  = add_ab[WIDTH];
        end
        R_LOAD: nxt.res = b;
        R_MVFR: nxt.res = a;
        R_MVTO: nxt.res = b;
        R_OR:   nxt.res = a | b;
        R_XOR:  nxt.res = a ^ b;
        R_XORR: nxt.res = {7'd0, ^b};
        R_AND:  nxt.res = a & b;
        R_STR:  nxt.res = b;
        R_SLT:  nxt.res = {7'd0, a < b};
        R_SEQ:  nxt.res = {7'd0, a == b};
        R_BTRU: begin
          nxt.res = a;
          nxt.br  = |a;
        end
        R_SUB: begin
          nxt.res = sub_ab[WIDTH-1:0];
          nxt.cy  = sub_ab[WIDTH];
        end
        default: nxt.res = '0;
      endcase
    end
  end

endmodule

// File: rtl/accum_alu.sv
// Accumulator ALU top: registered result and branch-taken.
// Optional Zero/Carry flag outputs when ALU_FLAGS_EN is defined.
module accum_alu
  import alu_pkg::*;
(
  input  logic             Clk,
  input  logic             ResetN,
  input  logic [WIDTH-1:0] AccumulatorIn,
  input  logic [WIDTH-1:0] OperandIn,
  input  logic [4:0]       ImmediateIn,
  input  logic             Type,
  input  logic [3:0]       RTypeOP,
  input  logic [2:0]       ITypeOP,
`ifdef ALU_FLAGS_EN
  output logic             Zero,
  output logic             Carry,
`endif
  output logic [WIDTH-1:0] Out,
  output logic             ConditionalBranch
);

  alu_res_t nxt;

  alu_comb u_comb (
    .a    (AccumulatorIn),
    .b    (OperandIn),
    .imm  (ImmediateIn),
    .typ  (Type),
    .r_op (RTypeOP),
    .i_op (ITypeOP),
    .nxt  (nxt)
  );

  // Capture result and branch; async reset clears them
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      Out               <= '0;
      ConditionalBranch <= 1'b0;
    end else begin
      Out               <= nxt.res;
      ConditionalBranch <= nxt.br;
    end
  end

`ifdef ALU_FLAGS_EN
  // Capture zero and carry/borrow flags of the next result
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      Zero  <= 1'b0;
      Carry <= 1'b0;
    end else begin
      Zero  <= (nxt.res == '0);
      Carry <= nxt.cy;
    end
  end
`else
  logic cy_unused;
  assign cy_unused = nxt.cy;
`endif

endmodule

// File: tb/tb_accum_alu.sv
// Testbench for accum_alu: directed plan plus random ops
// checked against an arithmetic reference model.
module tb_accum_alu;

  logic       Clk = 1'b0;
  logic       ResetN;
  logic [7:0] AccumulatorIn;
  logic [7:0] OperandIn;
  logic [4:0] ImmediateIn;
  logic       Type;
  logic [3:0] RTypeOP;
  logic [2:0] ITypeOP;
  logic [7:0] Out;
  logic       ConditionalBranch;
`ifdef ALU_FLAGS_EN
  logic       Zero;
  logic       Carry;
`endif

  int checks = 0;
  int failures = 0;

  accum_alu dut (
    .Clk               (Clk),
    .ResetN            (ResetN),
    .AccumulatorIn     (AccumulatorIn),
    .OperandIn         (OperandIn),
    .ImmediateIn       (ImmediateIn),
    .Type              (Type),
    .RTypeOP           (RTypeOP),
    .ITypeOP           (ITypeOP),
`ifdef ALU_FLAGS_EN
    .Zero              (Zero),
    .Carry             (Carry),
`endif
    .Out               (Out),
    .ConditionalBranch (ConditionalBranch)
  );

  always #5 Clk = ~Clk;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference model straight from the opcode table, integer arithmetic
  task automatic model(input int t, input int rop, input int iop,
                       input int a, input int b, input int imm,
                       output int o, output int cb,
                       output int z, output int cy);
    o = 0; cb = 0; cy = 0;
    if (t == 0) begin
      case (rop)
        0: begin o = (a + b) % 256; cy = (a + b > 255); end
        1, 3, 8: o = b;
        2: o = a;
        4: o = a | b;
        5: o = a ^ b;
        6: o = $countones(b[7:0]) % 2;
        7: o = a & b;
        9: o = (a < b) ? 1 : 0;
        10: o = (a == b) ? 1 : 0;
        11: begin o = a; cb = (a != 0); end
        12: begin o = (a - b + 256) % 256; cy = (a < b); end
        default: o = 0;
      endcase
    end else begin
      case (iop)
        0: o = imm;
        1: begin o = (a + imm) % 256; cy = (a + imm > 255); end
        2: begin o = (a - imm + 256) % 256; cy = (a < imm); end
        3: begin o = a; cb = 1; end
        4: o = (imm >= 8) ? 0 : (a * (1 << imm)) % 256;
        5: o = (imm >= 8) ? 0 : a / (1 << imm);
        default: o = 0;
      endcase
    end
    z = (o == 0);
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Apply one op, clock it, compare against model
  task automatic run(string tag, int t, int rop, int iop,
                     int a, int b, int imm);
    int o, cb, z, cy;
    Type = t[0];
    RTypeOP = rop[3:0];
    ITypeOP = iop[2:0];
    AccumulatorIn = a[7:0];
    OperandIn = b[7:0];
    ImmediateIn = imm[4:0];
    model(t, rop, iop, a, b, imm, o, cb, z, cy);
    step();
    check({tag, ".out"}, 32'(Out), 32'(o));
    check({tag, ".cb"}, 32'(ConditionalBranch), 32'(cb));
`ifdef ALU_FLAGS_EN
    check({tag, ".z"}, 32'(Zero), 32'(z));
    check({tag, ".cy"}, 32'(Carry), 32'(cy));
`endif
  endtask

  initial begin
    ResetN = 1'b0;
    Type = 1'b0;
    RTypeOP = 4'd0;
    ITypeOP = 3'd0;
    AccumulatorIn = 8'd1;
    OperandIn = 8'd1;
    ImmediateIn = 5'd0;
    repeat (2) step();
    check("rst.out", 32'(Out), 0);
    check("rst.cb", 32'(ConditionalBranch), 0);
`ifdef ALU_FLAGS_EN
    check("rst.z", 32'(Zero), 0);
    check("rst.cy", 32'(Carry), 0);
`endif
    #3;
    ResetN = 1'b1;
    step();
    check("rst_rel.out", 32'(Out), 2);

    run("add", 0, 0, 0, 255, 55, 0);
    check("add.lit", 32'(Out), 54);
    run("load", 0, 1, 0, 255, 55, 0);
    check("load.lit", 32'(Out), 55);
    run("mvto", 0, 3, 0, 255, 55, 0);
    run("or", 0, 4, 0, 255, 55, 0);
    check("or.lit", 32'(Out), 255);
    run("xor", 0, 5, 0, 255, 55, 0);
    check("xor.lit", 32'(Out), 200);
    run("xorr", 0, 6, 0, 255, 55, 0);
    check("xorr.lit", 32'(Out), 1);
    run("and", 0, 7, 0, 255, 55, 0);
    run("str", 0, 8, 0, 255, 55, 0);
    run("slt", 0, 9, 0, 10, 20, 0);
    check("slt.lit", 32'(Out), 1);
    run("seq", 0, 10, 0, 30, 30, 0);
    run("btru1", 0, 11, 0, 1, 0, 0);
    check("btru1.lit", 32'(ConditionalBranch), 1);
    run("btru0", 0, 11, 0, 0, 0, 0);
    check("btru0.lit", 32'(ConditionalBranch), 0);
    run("sub", 0, 12, 0, 70, 70, 0);
    check("sub.lit", 32'(Out), 0);
    run("r13", 0, 13, 0, 9, 9, 0);
    run("addi", 1, 0, 1, 100, 0, 20);
    check("addi.lit", 32'(Out), 120);
    run("subi", 1, 0, 2, 100, 0, 20);
    check("subi.lit", 32'(Out), 80);
    run("b", 1, 0, 3, 100, 0, 20);
    check("b.lit", 32'(ConditionalBranch), 1);
    run("subi_brw", 1, 0, 2, 5, 0, 20);
    check("subi_brw.lit", 32'(Out), 241);
    run("lsli", 1, 0, 4, 16, 0, 3);
    check("lsli.lit", 32'(Out), 128);
    run("lsri", 1, 0, 5, 16, 0, 3);
    check("lsri.lit", 32'(Out), 2);
    run("lsli_big", 1, 0, 4, 16, 0, 9);
    check("lsli_big.lit", 32'(Out), 0);
    run("lsri_big", 1, 0, 5, 255, 0, 8);
    run("li", 1, 0, 0, 0, 0, 31);
    check("li.lit", 32'(Out), 31);
    run("i7", 1, 0, 7, 3, 3, 3);

    run("lat_add", 0, 0, 0, 255, 55, 0);
    RTypeOP = 4'd1;
    #3;
    check("lat_hold", 32'(Out), 54);
    step();
    check("lat_edge", 32'(Out), 55);
    #2;
    ResetN = 1'b0;
    #1;
    check("async_rst.out", 32'(Out), 0);
    check("async_rst.cb", 32'(ConditionalBranch), 0);
    #1;
    ResetN = 1'b1;
    step();
    check("async_rel", 32'(Out), 55);

    for (int i = 0; i < 400; i++) begin
      run("rand", int'($urandom_range(0, 1)),
          int'($urandom_range(0, 15)), int'($urandom_range(0, 7)),
          int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
          int'($urandom_range(0, 31)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/accum_alu.md
Name: accum_alu

Overview:
- Accumulator-style ALU for the 8-bit single-cycle processor datapath. It sits between the register file/accumulator and the writeback mux.
- Decodes a type bit plus an R-type (4-bit) or I-type (3-bit) opcode. Produces an 8-bit result and a branch-taken signal.
- Outputs are registered: one clock of latency, asynchronous active-low reset.

Parameters:
- WIDTH, 8, data path width. Only 8 is supported; the shift and reduction rules below assume 8.

Ports:
- Clk  input  1  rising-edge clock
- ResetN  input  1  asynchronous active-low reset
- AccumulatorIn  input  8  accumulator operand (A)
- OperandIn  input  8  register operand (B)
- ImmediateIn  input  5  immediate, zero-extended to 8 bits (I)
- Type  input  1  0 selects the R-type opcode, 1 selects the I-type opcode
- RTypeOP  input  4  R-type opcode, used when Type=0
- ITypeOP  input  3  I-type opcode, used when Type=1
- Out  output  8  registered result
- ConditionalBranch  output  1  registered branch-taken signal
- Interface: one clock; reset is asynchronous and active-low (Clk, ResetN).

Behaviour:
- Combinational next-value logic, captured into the Out and ConditionalBranch registers on each rising Clk. Result is visible one cycle after the inputs are applied.
- ResetN=0 forces Out=0 and ConditionalBranch=0 immediately, independent of Clk. They stay 0 until the first rising edge after ResetN deasserts.
- Reset asserted mid-operation discards the pending result; there is no other state.
- All arithmetic is mod 256; carries and borrows are discarded from Out.
- Compares are unsigned.
- ConditionalBranch is 0 unless an opcode rule below says otherwise.
- R-type (Type=0):
  - 0 ADD: A+B
  - 1 LOAD: B
  - 2 MVFR: A
  - 3 MVTO: B
  - 4 OR: A|B
  - 5 XOR: A^B
  - 6 XORR: {7'b0, reduction-XOR of B}
  - 7 AND: A&B
  - 8 STR: B (store address passthrough)
  - 9 SLT: 1 if A<B, else 0
  - 10 SEQ: 1 if A==B, else 0
  - 11 BTRU: Out=A; ConditionalBranch=1 when A!=0
  - 12 SUB: A-B
  - 13-15: Out=0
- I-type (Type=1):
  - 0 LI: I
  - 1 ADDI: A+I
  - 2 SUBI: A-I
  - 3 B: Out=A; ConditionalBranch=1 (unconditional)
  - 4 LSLI: A<<I[4:0], zero fill; shift amounts 8-31 give 0
  - 5 LSRI: A>>I[4:0], logical; shift amounts 8-31 give 0
  - 6-7: Out=0
- The unused opcode field is ignored, including any X values on it.

Optional Feature:
- Macro ALU_FLAGS_EN.
- When defined, add two registered 1-bit outputs, both reset to 0:
  - Zero: next Out==0.
  - Carry: carry-out of ADD/ADDI, borrow (A<B or A<I) of SUB/SUBI, 0 for all other ops.
- When undefined, these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package alu_pkg holds:
  - enum r_op_t (ADD, LOAD, MVFR, MVTO, OR, XOR, XORR, AND, STR, SLT, SEQ, BTRU, SUB)
  - enum i_op_t (LI, ADDI, SUBI, B, LSLI, LSRI)
  - constant WIDTH=8
- One sub-module is natural: alu_comb, the purely combinational opcode decode and datapath.
- The top level adds only the output registers, the reset, and the optional flags.

Test Plan:
- Reset: hold ResetN=0 with Type=0, RTypeOP=0, A=1, B=1 -> Out=0, CB=0; release and clock once -> Out=2.
- R logic/arith, A=255, B=55, one cycle per op:
  - ADD -> 54
  - LOAD -> 55
  - MVTO -> 55
  - OR -> 255
  - XOR -> 200
  - XORR -> 1
  - AND -> 55
  - STR -> 55
- R compare/branch:
  - A=10, B=20, SLT -> 1
  - A=30, B=30, SEQ -> 1
  - A=1, BTRU -> Out=1, CB=1
  - A=0, BTRU -> CB=0
  - A=70, B=70, SUB -> 0 (Zero=1 with ALU_FLAGS_EN)
- I arith/branch:
  - Type=1, A=100, I=20: ADDI -> 120, SUBI -> 80, B -> CB=1
  - A=5, I=20: SUBI -> 241 (Carry=1 with ALU_FLAGS_EN)
- Shifts:
  - A=16, I=3: LSLI -> 128, LSRI -> 2
  - A=16, I=9: LSLI -> 0
  - LI with I=31 -> 31
- Latency/async reset: change RTypeOP between edges -> Out updates only on the edge; pulse ResetN low between edges -> Out drops to 0 immediately.
